// File: rtl/pot_scan_ctrl.sv
// Shared POKEY paddle scanner: dumps all eight pot capacitors, runs one scan
// counter, and captures each channel's count when its comparator trips.
module pot_scan_ctrl #(
    parameter int MAX_COUNT  = 228,
    parameter int DUMP_TICKS = 2,
    parameter int CW         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_tick,
    input  logic              fast_scan,
    input  logic              potgo_wr,
    input  logic [7:0]        pot_in,
    output logic              pot_dump,
    output logic [8*CW-1:0]   pot_val,
    output logic [7:0]        allpot,
    output logic              scan_busy,
    output logic              scan_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DUMP = 2'd1,
        SCAN = 2'd2
    } state_t;

    localparam logic [CW-1:0] MAX_C     = CW'(MAX_COUNT);
    localparam logic [CW-1:0] DUMP_LAST = CW'(DUMP_TICKS - 1);

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [7:0]        allpot_q;
    logic [8*CW-1:0]   pot_val_q;
    logic [8*CW-1:0]   pot_val_d;
    logic              pot_dump_q;
    logic              scan_busy_q;
    logic              scan_done_q;

    logic              tick_s;
    logic              timeout_s;
    logic [7:0]        cap_s;
    logic [7:0]        rest_s;

    assign tick_s    = fast_scan ? 1'b1 : line_tick;
    assign timeout_s = (cnt_q == MAX_C);
    assign cap_s     = allpot_q & pot_in;
    assign rest_s    = allpot_q & ~pot_in;

    // Per-channel value a SCAN tick would write: timeout forces pending channels to MAX_COUNT.
    always_comb begin
        pot_val_d = pot_val_q;
        for (int n = 0; n < 8; n++) begin
            if (timeout_s) begin
                if (allpot_q[n]) begin
                    pot_val_d[n*CW +: CW] = MAX_C;
                end else begin
                    pot_val_d[n*CW +: CW] = pot_val_q[n*CW +: CW];
                end
            end else if (cap_s[n]) begin
                pot_val_d[n*CW +: CW] = cnt_q;
            end else begin
                pot_val_d[n*CW +: CW] = pot_val_q[n*CW +: CW];
            end
        end
    end

    // Scan sequencer with registered outputs; potgo_wr restarts from any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= {CW{1'b0}};
            allpot_q    <= 8'h00;
            pot_val_q   <= {(8*CW){1'b0}};
            pot_dump_q  <= 1'b1;
            scan_busy_q <= 1'b0;
            scan_done_q <= 1'b0;
        end else begin
            scan_done_q <= 1'b0;
            case (state_q)
                IDLE, DUMP, SCAN: begin
                    if (potgo_wr) begin
                        state_q     <= DUMP;
                        cnt_q       <= {CW{1'b0}};
                        allpot_q    <= 8'hFF;
                        pot_dump_q  <= 1'b1;
                        scan_busy_q <= 1'b1;
                    end else if (!tick_s || state_q == IDLE) begin
                        state_q <= state_q;
                    end else if (state_q == DUMP) begin
                        if (cnt_q == DUMP_LAST) begin
                            cnt_q      <= {CW{1'b0}};
                            state_q    <= SCAN;
                            pot_dump_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        pot_val_q <= pot_val_d;
                        // Scan ends on timeout or once no channel remains pending.
                        if (timeout_s || rest_s == 8'h00) begin
                            allpot_q    <= 8'h00;
                            state_q     <= IDLE;
                            scan_done_q <= 1'b1;
                            scan_busy_q <= 1'b0;
                            pot_dump_q  <= 1'b1;
                        end else begin
                            allpot_q <= rest_s;
                        end
                        if (timeout_s) begin
                            cnt_q <= cnt_q;
                        end else begin
                            cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= {CW{1'b0}};
                    allpot_q    <= 8'h00;
                    pot_val_q   <= {(8*CW){1'b0}};
                    pot_dump_q  <= 1'b1;
                    scan_busy_q <= 1'b0;
                    scan_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign pot_dump  = pot_dump_q;
    assign pot_val   = pot_val_q;
    assign allpot    = allpot_q;
    assign scan_busy = scan_busy_q;
    assign scan_done = scan_done_q;

endmodule

// File: tb/tb_pot_scan_ctrl.sv
// Randomized and directed bench for pot_scan_ctrl, checked every cycle against
// a phase/tick-index model of the paddle scan.
module tb_pot_scan_ctrl;

    localparam int MAXC  = 228;
    localparam int DUMPT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        line_tick = 1'b0;
    logic        fast_scan = 1'b0;
    logic        potgo_wr = 1'b0;
    logic [7:0]  pot_in = 8'h00;
    logic        pot_dump;
    logic [63:0] pot_val;
    logic [7:0]  allpot;
    logic        scan_busy;
    logic        scan_done;

    pot_scan_ctrl #(.MAX_COUNT(MAXC), .DUMP_TICKS(DUMPT), .CW(8)) dut (
        .clk(clk), .rst(rst), .line_tick(line_tick), .fast_scan(fast_scan),
        .potgo_wr(potgo_wr), .pot_in(pot_in), .pot_dump(pot_dump),
        .pot_val(pot_val), .allpot(allpot), .scan_busy(scan_busy),
        .scan_done(scan_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    bit chk_en = 1'b0;
    int lt_mode = 0;
    int lt_div = 0;

    // Model: phase 0=idle 1=dump 2=scan; m_k is the index of the next scan tick.
    int  m_phase = 0;
    int  m_dcount = 0;
    int  m_k = 0;
    bit  m_pend [8];
    int  m_val [8];
    bit  m_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] m_potval();
        logic [63:0] v;
        for (int n = 0; n < 8; n++) v[8*n +: 8] = 8'(m_val[n]);
        return v;
    endfunction

    function automatic logic [7:0] m_allpot();
        logic [7:0] v;
        for (int n = 0; n < 8; n++) v[n] = m_pend[n];
        return v;
    endfunction

    always @(posedge clk) begin
        bit tick;
        bit any;
        tick = fast_scan ? 1'b1 : line_tick;
        m_done = 1'b0;
        if (rst) begin
            m_phase = 0; m_dcount = 0; m_k = 0;
            for (int n = 0; n < 8; n++) begin m_pend[n] = 1'b0; m_val[n] = 0; end
        end else if (potgo_wr) begin
            m_phase = 1; m_dcount = 0;
            for (int n = 0; n < 8; n++) m_pend[n] = 1'b1;
        end else if (tick && m_phase == 1) begin
            m_dcount++;
            if (m_dcount == DUMPT) begin m_phase = 2; m_k = 0; end
        end else if (tick && m_phase == 2) begin
            if (m_k == MAXC) begin
                for (int n = 0; n < 8; n++)
                    if (m_pend[n]) begin m_val[n] = MAXC; m_pend[n] = 1'b0; end
            end else begin
                for (int n = 0; n < 8; n++)
                    if (m_pend[n] && pot_in[n]) begin m_val[n] = m_k; m_pend[n] = 1'b0; end
                m_k++;
            end
            any = 1'b0;
            for (int n = 0; n < 8; n++) any |= m_pend[n];
            if (!any) begin m_phase = 0; m_done = 1'b1; end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pot_val", pot_val, m_potval());
            chk("allpot", {56'd0, allpot}, {56'd0, m_allpot()});
            chk("pot_dump", {63'd0, pot_dump}, {63'd0, (m_phase != 2)});
            chk("scan_busy", {63'd0, scan_busy}, {63'd0, (m_phase != 0)});
            chk("scan_done", {63'd0, scan_done}, {63'd0, m_done});
            if (scan_done) done_cnt++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (lt_mode == 1) begin
                lt_div = (lt_div + 1) % 4;
                line_tick = (lt_div == 0);
            end else if (lt_mode == 2) begin
                line_tick = ($urandom_range(0, 2) == 0);
            end else begin
                line_tick = 1'b0;
            end
        end
    end

    task automatic pulse_potgo();
        potgo_wr = 1'b1;
        @(negedge clk);
        potgo_wr = 1'b0;
    endtask

    task automatic wait_k(input int k);
        int n = 0;
        while (!(m_phase == 2 && m_k == k) && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) chk("wait_k_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_phase != 0 && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) chk("wait_idle_timeout", 64'd0, 64'd1);
        @(negedge clk);
    endtask

    initial begin
        int d0;
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("rst_pot_dump", {63'd0, pot_dump}, 64'd1);
        chk("rst_allpot", {56'd0, allpot}, 64'd0);
        chk("rst_pot_val", pot_val, 64'd0);
        chk("rst_busy", {63'd0, scan_busy}, 64'd0);
        chk_en = 1'b1;
        rst = 1'b0;

        // Fast scan, channel 3 trips at tick 10, rest time out.
        fast_scan = 1'b1; pot_in = 8'h00; d0 = done_cnt;
        pulse_potgo();
        wait_k(10);
        pot_in = 8'h08;
        wait_idle();
        chk("fast_potval", pot_val, 64'hE4E4E4E40AE4E4E4);
        chk("fast_allpot", {56'd0, allpot}, 64'd0);
        chk("fast_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("fast_dump", {63'd0, pot_dump}, 64'd1);

        // Line-tick mode, every channel already charged at SCAN entry.
        fast_scan = 1'b0; lt_mode = 1; pot_in = 8'h00; d0 = done_cnt;
        pulse_potgo();
        while (m_phase != 2) @(negedge clk);
        pot_in = 8'hFF;
        wait_idle();
        chk("line_potval", pot_val, 64'd0);
        chk("line_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Staggered channels, bit n rises at tick 5n+1.
        fast_scan = 1'b1; lt_mode = 0; pot_in = 8'h00;
        pulse_potgo();
        for (int k = 0; k <= 36; k++) begin
            wait_k(k);
            for (int n = 0; n < 8; n++) if (5 * n + 1 <= k) pot_in[n] = 1'b1;
        end
        wait_idle();
        chk("stagger_potval", pot_val, 64'h241F1A15100B0601);

        // Restart mid-scan after POT0 captured 20.
        pot_in = 8'h00; d0 = done_cnt;
        pulse_potgo();
        wait_k(20);
        pot_in = 8'h01;
        wait_k(50);
        pulse_potgo();
        chk("restart_pot0", {56'd0, pot_val[7:0]}, 64'd20);
        chk("restart_allpot", {56'd0, allpot}, 64'hFF);
        chk("restart_no_done", 64'(done_cnt - d0), 64'd0);
        wait_idle();
        chk("restart_rescan", pot_val, 64'hE4E4E4E4E4E4E400);

        // POTGO on the timeout tick wins over completion.
        pot_in = 8'h00; d0 = done_cnt;
        pulse_potgo();
        wait_k(MAXC);
        pulse_potgo();
        chk("coinc_allpot", {56'd0, allpot}, 64'hFF);
        chk("coinc_potval", pot_val, 64'hE4E4E4E4E4E4E400);
        chk("coinc_no_done", 64'(done_cnt - d0), 64'd0);

        // Reset at tick 100, then a normal scan.
        wait_k(100);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_potval", pot_val, 64'd0);
        chk("midrst_allpot", {56'd0, allpot}, 64'd0);
        chk("midrst_busy", {63'd0, scan_busy}, 64'd0);
        chk("midrst_dump", {63'd0, pot_dump}, 64'd1);
        pot_in = 8'hA5;
        pulse_potgo();
        wait_idle();
        chk("post_rst_scan", pot_val, 64'h00E400E4E400E400);

        // Random traffic.
        lt_mode = 2;
        for (int c = 0; c < 6000; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            potgo_wr = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 49) == 0) fast_scan = ~fast_scan;
            if (potgo_wr) pot_in = 8'h00;
            else if ($urandom_range(0, 99) == 0) pot_in = 8'($urandom);
            else if ($urandom_range(0, 9) == 0) pot_in[$urandom_range(0, 7)] = 1'b1;
            else pot_in = pot_in;
            @(negedge clk);
        end
        rst = 1'b0; potgo_wr = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pot_scan_ctrl.md
Name: pot_scan_ctrl

Overview:
Sequences the eight POKEY paddle (POT) channels through one shared scan counter: capacitor dump, timed count, and per-channel capture. It replaces per-channel free-running scanners with a single POTGO-triggered scan. It produces POT0–POT7 values and the ALLPOT status byte for the POKEY register read mux. The scan rate is the 15.7 kHz line tick, or the system clock when fast scan (SKCTL bit 2) is selected.

Parameters:
MAX_COUNT, 228, terminal count; pending channels are forced to this value when the scan times out
DUMP_TICKS, 2, number of scan ticks the capacitors are held grounded after POTGO
CW, 8, width of the scan counter and of each POT value

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
line_tick  in  1  one-cycle pulse at 15.7 kHz (scan tick when fast_scan=0)
fast_scan  in  1  SKCTL[2]; 1 = scan tick every clk cycle
potgo_wr  in  1  one-cycle strobe from a POTGO register write
pot_in  in  8  comparator outputs, already synchronized to clk; 1 = capacitor charged past threshold
pot_dump  out  1  1 = ground all pot capacitors
pot_val  out  64  POTn value at bits [8n+7:8n]
allpot  out  8  ALLPOT; bit n = 1 while channel n is still pending
scan_busy  out  1  1 in DUMP or SCAN
scan_done  out  1  one-cycle pulse when a scan completes

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state=IDLE, pot_dump=1, allpot=0x00, pot_val=0, cnt=0, scan_busy=0, scan_done=0.
- Scan tick: tick = fast_scan ? 1 : line_tick, evaluated combinationally each cycle.
- States: IDLE, DUMP, SCAN (2-bit encoding). Any undefined encoding returns to IDLE with reset values.
- IDLE:
  - pot_dump=1; pot_val and allpot hold.
  - potgo_wr -> DUMP next cycle with cnt<=0 and allpot<=0xFF.
- DUMP:
  - pot_dump=1; cnt increments on each tick.
  - On the tick where cnt==DUMP_TICKS-1: cnt<=0, go to SCAN.
- SCAN:
  - pot_dump=0. On each tick, let pend=allpot.
  - If cnt==MAX_COUNT: every pend channel gets pot_val<=MAX_COUNT and allpot<=0. Go to IDLE and pulse scan_done.
  - Else: each channel with pend[n]&pot_in[n] gets pot_val[n]<=cnt (the pre-increment value) and allpot[n]<=0; cnt<=cnt+1.
  - If pend&~pot_in==0 after the capture, go to IDLE and pulse scan_done in the same cycle.
  - No tick: everything holds.
- Capture rules:
  - Channels already captured ignore pot_in for the rest of the scan.
  - A channel whose pot_in is already high on the first SCAN tick captures 0.
- Register update timing: all updates are registered, so pot_val, allpot and scan_done change one clk after the qualifying tick edge.
- potgo_wr during DUMP or SCAN restarts the scan: DUMP, cnt<=0, allpot<=0xFF.
  - pot_val entries not yet recaptured keep their previous values.
  - No scan_done pulse for the aborted scan.
- potgo_wr coincident with the final SCAN tick: restart wins. No scan_done; captures from that tick are discarded (allpot=0xFF).
- rst mid-scan: immediate return to reset values, including pot_val=0.
- Output decode:
  - scan_busy = (state!=IDLE).
  - pot_dump = (state!=SCAN).
- Arithmetic: cnt is CW bits, unsigned, and never exceeds MAX_COUNT (MAX_COUNT < 2^CW is required), so it never wraps.
- fast_scan may change mid-scan; the new tick source takes effect the next cycle.

Test Plan:
- Reset: rst high for 2 cycles -> pot_dump=1, allpot=0x00, pot_val=0, scan_busy=0.
- Fast scan, pot_in[3] rising 10 ticks into SCAN, others low:
  - potgo_wr -> 2 DUMP cycles, then allpot[3] clears with POT3=10.
  - Remaining channels capture 228 at the timeout tick; allpot=0x00; one scan_done pulse; pot_dump returns to 1.
- Line-tick mode, line_tick every 4 clks, pot_in=0xFF from SCAN entry -> all POTn=0, scan_done on the first SCAN tick.
- Staggered pot_in bits n rising at SCAN tick 5n+1 -> POTn=5n+1, allpot bits clear in order LSB first, scan_done when bit 7 clears.
- Restart: potgo_wr at SCAN tick 50 with POT0 already captured at 20 and others pending:
  - POT0 stays 20, allpot returns to 0xFF, DUMP re-entered, no scan_done.
  - The next scan overwrites POT0.
- rst asserted at SCAN tick 100 -> next cycle all outputs at reset values; a subsequent potgo_wr starts a normal scan.
